// File: rtl/ex_mem_skid_pkg.sv
// Shared constants and state encoding for the EX->MEM skid stage.
// Also used by the bench for the NOP field values.
package ex_mem_skid_pkg;

   localparam logic       RST_ENABLE   = 1'b1;
   localparam logic [4:0] NOP_REG_ADDR = 5'b00000;
   localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000;
   localparam logic [2:0] EXE_RES_NOP  = 3'b000;
   localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;

   // The encoding doubles as the occupancy count.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_e;

endpackage

// File: rtl/ex_mem_skid_if.sv
// EX->MEM handshake bus.
// slave = the pipeline stage, master = the EX/MEM side driving it.
interface ex_mem_skid_if #(
   parameter int WD_W     = 5,
   parameter int DATA_W   = 32,
   parameter int ALUOP_W  = 8,
   parameter int ALUSEL_W = 3,
   parameter int ADDR_W   = 32
);
   logic                in_valid;
   logic                in_ready;
   logic [WD_W-1:0]     ex_wd;
   logic                ex_wreg;
   logic [DATA_W-1:0]   ex_wdata;
   logic [ALUOP_W-1:0]  ex_aluop;
   logic [ALUSEL_W-1:0] ex_alusel;
   logic [ADDR_W-1:0]   ex_ma_addr;

   logic                out_valid;
   logic                out_ready;
   logic [WD_W-1:0]     mem_wd;
   logic                mem_wreg;
   logic [DATA_W-1:0]   mem_wdata;
   logic [ALUOP_W-1:0]  mem_aluop;
   logic [ALUSEL_W-1:0] mem_alusel;
   logic [ADDR_W-1:0]   mem_ma_addr;

   modport slave (
      input  in_valid, ex_wd, ex_wreg, ex_wdata, ex_aluop, ex_alusel, ex_ma_addr, out_ready,
      output in_ready, out_valid, mem_wd, mem_wreg, mem_wdata, mem_aluop, mem_alusel, mem_ma_addr
   );

   modport master (
      output in_valid, ex_wd, ex_wreg, ex_wdata, ex_aluop, ex_alusel, ex_ma_addr, out_ready,
      input  in_ready, out_valid, mem_wd, mem_wreg, mem_wdata, mem_aluop, mem_alusel, mem_ma_addr
   );
endinterface

// File: rtl/ex_mem_skid_pipe_slot.sv
// Payload register with load enable and synchronous clear (clear wins).
module pipe_slot #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         clr_i,
   input  logic         ld_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);
   logic [W-1:0] slot_q;

   always_ff @(posedge clk) begin
      if (clr_i) slot_q <= '0;
      else if (ld_i) slot_q <= d_i;
   end

   assign q_o = slot_q;
endmodule

// File: rtl/ex_mem_skid.sv
// EX->MEM stage: valid/ready handshake with a main slot plus one skid slot.
// in_ready/out_valid are pure state decodes, so out_ready never reaches in_ready.
module ex_mem_skid
   import ex_mem_skid_pkg::*;
#(
   parameter int WD_W        = 5,
   parameter int DATA_W      = 32,
   parameter int ALUOP_W     = 8,
   parameter int ALUSEL_W    = 3,
   parameter int ADDR_W      = 32,
   parameter int BUBBLE_ZERO = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   ex_mem_skid_if.slave      bus,
   output logic [1:0]        count
);
   localparam int PW = WD_W + 1 + DATA_W + ALUOP_W + ALUSEL_W + ADDR_W;

   state_e          state_q, state_d;
   logic            in_fire, out_fire;
   logic            main_ld, skid_ld, main_from_skid;
   logic            slot_clr;
   logic [PW-1:0]   in_pl, main_d, main_q, skid_q;

   logic [WD_W-1:0]     m_wd;
   logic                m_wreg;
   logic [DATA_W-1:0]   m_wdata;
   logic [ALUOP_W-1:0]  m_aluop;
   logic [ALUSEL_W-1:0] m_alusel;
   logic [ADDR_W-1:0]   m_addr;

   assign bus.in_ready  = (state_q != TWO);
   assign bus.out_valid = (state_q != EMPTY);
   assign count         = state_q;

   assign in_fire  = bus.in_valid & bus.in_ready;
   assign out_fire = bus.out_valid & bus.out_ready;
   assign slot_clr = (rst == RST_ENABLE);

   assign in_pl  = {bus.ex_wd, bus.ex_wreg, bus.ex_wdata, bus.ex_aluop, bus.ex_alusel, bus.ex_ma_addr};
   assign main_d = main_from_skid ? skid_q : in_pl;

   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) state_q <= EMPTY;
      else                   state_q <= state_d;
   end

   always_comb begin
      state_d        = state_q;
      main_ld        = 1'b0;
      skid_ld        = 1'b0;
      main_from_skid = 1'b0;
      unique case (state_q)
         EMPTY: begin
            if (in_fire) begin
               state_d = ONE;
               main_ld = 1'b1;
            end
         end
         ONE: begin
            if (in_fire && out_fire) begin
               main_ld = 1'b1;
            end else if (out_fire) begin
               state_d = EMPTY;
            end else if (in_fire) begin
               state_d = TWO;
               skid_ld = 1'b1;
            end
         end
         TWO: begin
            if (out_fire) begin
               state_d        = ONE;
               main_ld        = 1'b1;
               main_from_skid = 1'b1;
            end
         end
         default: state_d = EMPTY;
      endcase
      // Flush leaves the slot contents alone so hold-last-value mode keeps showing them.
      if (flush) begin
         state_d = EMPTY;
         main_ld = 1'b0;
         skid_ld = 1'b0;
      end
   end

   pipe_slot #(.W(PW)) u_main (
      .clk   (clk),
      .clr_i (slot_clr),
      .ld_i  (main_ld),
      .d_i   (main_d),
      .q_o   (main_q)
   );

   pipe_slot #(.W(PW)) u_skid (
      .clk   (clk),
      .clr_i (slot_clr),
      .ld_i  (skid_ld),
      .d_i   (in_pl),
      .q_o   (skid_q)
   );

   assign {m_wd, m_wreg, m_wdata, m_aluop, m_alusel, m_addr} = main_q;

   always_comb begin
      bus.mem_wd      = m_wd;
      bus.mem_wreg    = m_wreg & bus.out_valid;
      bus.mem_wdata   = m_wdata;
      bus.mem_aluop   = m_aluop;
      bus.mem_alusel  = m_alusel;
      bus.mem_ma_addr = m_addr;
      if ((BUBBLE_ZERO != 0) && !bus.out_valid) begin
         bus.mem_wd      = WD_W'(NOP_REG_ADDR);
         bus.mem_wdata   = DATA_W'(ZERO_WORD);
         bus.mem_aluop   = ALUOP_W'(EXE_NOP_OP);
         bus.mem_alusel  = ALUSEL_W'(EXE_RES_NOP);
         bus.mem_ma_addr = ADDR_W'(ZERO_WORD);
      end
   end
endmodule

// File: tb/tb_ex_mem_skid.sv
// Bench for ex_mem_skid: one instance per bubble mode, driven identically and
// checked against a two-deep FIFO reference model plus fixed-value sequences.
module tb_ex_mem_skid;
   import ex_mem_skid_pkg::*;

   localparam int WD_W     = 5;
   localparam int DATA_W   = 32;
   localparam int ALUOP_W  = 8;
   localparam int ALUSEL_W = 3;
   localparam int ADDR_W   = 32;

   typedef struct packed {
      logic [WD_W-1:0]     wd;
      logic                wreg;
      logic [DATA_W-1:0]   wdata;
      logic [ALUOP_W-1:0]  aluop;
      logic [ALUSEL_W-1:0] alusel;
      logic [ADDR_W-1:0]   addr;
   } pl_t;

   typedef struct {
      logic              iv, ordy, fl;
      logic [WD_W-1:0]   wd;
      logic [DATA_W-1:0] wdata;
      logic [1:0]        e_cnt;
      logic              e_ov, e_ir;
      logic [WD_W-1:0]   e_wd;
      logic [DATA_W-1:0] e_wdata;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst, flush;
   logic [1:0] count1, count0;

   ex_mem_skid_if #(.WD_W(WD_W), .DATA_W(DATA_W), .ALUOP_W(ALUOP_W), .ALUSEL_W(ALUSEL_W), .ADDR_W(ADDR_W)) b1 ();
   ex_mem_skid_if #(.WD_W(WD_W), .DATA_W(DATA_W), .ALUOP_W(ALUOP_W), .ALUSEL_W(ALUSEL_W), .ADDR_W(ADDR_W)) b0 ();

   ex_mem_skid #(.WD_W(WD_W), .DATA_W(DATA_W), .ALUOP_W(ALUOP_W), .ALUSEL_W(ALUSEL_W),
                 .ADDR_W(ADDR_W), .BUBBLE_ZERO(1)) dut1 (
      .clk(clk), .rst(rst), .flush(flush), .bus(b1.slave), .count(count1));

   ex_mem_skid #(.WD_W(WD_W), .DATA_W(DATA_W), .ALUOP_W(ALUOP_W), .ALUSEL_W(ALUSEL_W),
                 .ADDR_W(ADDR_W), .BUBBLE_ZERO(0)) dut0 (
      .clk(clk), .rst(rst), .flush(flush), .bus(b0.slave), .count(count0));

   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_fail   = 0;
   pl_t  q[$];
   pl_t  last_head;
   pl_t  cur;
   logic iv, ordy;
   vec_t tbl[13];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic pl_t mk(input logic [WD_W-1:0] wd, input logic [DATA_W-1:0] wdata);
      pl_t p;
      p.wd     = wd;
      p.wreg   = 1'b1;
      p.wdata  = wdata;
      p.aluop  = 8'h21;
      p.alusel = 3'd4;
      p.addr   = wdata ^ 32'h1000_0000;
      return p;
   endfunction

   task automatic set_in(input logic v, input logic r, input logic f, input pl_t p);
      iv = v; ordy = r; flush = f; cur = p;
      b1.in_valid = v;  b0.in_valid = v;
      b1.out_ready = r; b0.out_ready = r;
      {b1.ex_wd, b1.ex_wreg, b1.ex_wdata, b1.ex_aluop, b1.ex_alusel, b1.ex_ma_addr} = p;
      {b0.ex_wd, b0.ex_wreg, b0.ex_wdata, b0.ex_aluop, b0.ex_alusel, b0.ex_ma_addr} = p;
   endtask

   // Reference: a FIFO of capacity two; the displayed head persists after draining.
   task automatic model_edge();
      logic can_in, has_out;
      if (rst) begin
         q.delete();
         last_head = '0;
      end else begin
         if (q.size() > 0) last_head = q[0];
         can_in  = (q.size() < 2);
         has_out = (q.size() > 0);
         if (flush) begin
            q.delete();
         end else begin
            if (has_out && ordy) void'(q.pop_front());
            if (iv && can_in) q.push_back(cur);
         end
         if (q.size() > 0) last_head = q[0];
      end
   endtask

   function automatic logic [84:0] expect_out(input bit bz);
      pl_t  h;
      logic v;
      v = (q.size() > 0);
      if (v) begin
         h = q[0];
      end else if (bz) begin
         h.wd     = NOP_REG_ADDR;
         h.wreg   = 1'b0;
         h.wdata  = ZERO_WORD;
         h.aluop  = EXE_NOP_OP;
         h.alusel = EXE_RES_NOP;
         h.addr   = ZERO_WORD;
      end else begin
         h = last_head;
         h.wreg = 1'b0;
      end
      return {2'(q.size()), (q.size() < 2), v, h};
   endfunction

   function automatic logic [84:0] out1();
      return {count1, b1.in_ready, b1.out_valid, b1.mem_wd, b1.mem_wreg, b1.mem_wdata,
              b1.mem_aluop, b1.mem_alusel, b1.mem_ma_addr};
   endfunction

   function automatic logic [84:0] out0();
      return {count0, b0.in_ready, b0.out_valid, b0.mem_wd, b0.mem_wreg, b0.mem_wdata,
              b0.mem_aluop, b0.mem_alusel, b0.mem_ma_addr};
   endfunction

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      chk("model_bz1", out1(), expect_out(1'b1));
      chk("model_bz0", out0(), expect_out(1'b0));
   endtask

   initial begin
      logic [95:0] r;

      tbl[0]  = '{1'b1, 1'b0, 1'b0, 5'd1, 32'hA1, 2'd1, 1'b1, 1'b1, 5'd1, 32'hA1};
      tbl[1]  = '{1'b1, 1'b0, 1'b0, 5'd2, 32'hB2, 2'd2, 1'b1, 1'b0, 5'd1, 32'hA1};
      tbl[2]  = '{1'b1, 1'b0, 1'b0, 5'd3, 32'hC3, 2'd2, 1'b1, 1'b0, 5'd1, 32'hA1};
      tbl[3]  = '{1'b0, 1'b1, 1'b0, 5'd0, 32'h0,  2'd1, 1'b1, 1'b1, 5'd2, 32'hB2};
      tbl[4]  = '{1'b0, 1'b1, 1'b0, 5'd0, 32'h0,  2'd0, 1'b0, 1'b1, 5'd0, 32'h0};
      tbl[5]  = '{1'b1, 1'b1, 1'b0, 5'd4, 32'hD4, 2'd1, 1'b1, 1'b1, 5'd4, 32'hD4};
      tbl[6]  = '{1'b1, 1'b1, 1'b0, 5'd5, 32'hE5, 2'd1, 1'b1, 1'b1, 5'd5, 32'hE5};
      tbl[7]  = '{1'b0, 1'b1, 1'b0, 5'd0, 32'h0,  2'd0, 1'b0, 1'b1, 5'd0, 32'h0};
      tbl[8]  = '{1'b1, 1'b0, 1'b0, 5'd6, 32'hF6, 2'd1, 1'b1, 1'b1, 5'd6, 32'hF6};
      tbl[9]  = '{1'b1, 1'b0, 1'b0, 5'd7, 32'h77, 2'd2, 1'b1, 1'b0, 5'd6, 32'hF6};
      tbl[10] = '{1'b1, 1'b0, 1'b1, 5'd8, 32'h88, 2'd0, 1'b0, 1'b1, 5'd0, 32'h0};
      tbl[11] = '{1'b1, 1'b1, 1'b1, 5'd9, 32'h99, 2'd0, 1'b0, 1'b1, 5'd0, 32'h0};
      tbl[12] = '{1'b0, 1'b1, 1'b0, 5'd0, 32'h0,  2'd0, 1'b0, 1'b1, 5'd0, 32'h0};

      // Reset with a pending entry that must be ignored.
      rst = 1'b1;
      set_in(1'b1, 1'b1, 1'b0, mk(5'd3, 32'h1234));
      repeat (2) begin
         tick();
         chk("rst_out_valid", b1.out_valid, 1'b0);
         chk("rst_mem_wreg", {b1.mem_wreg, b0.mem_wreg}, 2'b00);
         chk("rst_mem_aluop", b1.mem_aluop, EXE_NOP_OP);
         chk("rst_count_ready", {count1, b1.in_ready}, {2'd0, 1'b1});
      end
      rst = 1'b0;
      set_in(1'b1, 1'b1, 1'b0, mk(5'd5, 32'hDEADBEEF));
      tick();
      chk("first_accept", {b1.out_valid, b1.mem_wd, b1.mem_wdata}, {1'b1, 5'd5, 32'hDEADBEEF});

      // Back-to-back stream at full rate.
      for (int i = 0; i < 4; i++) begin
         set_in(1'b1, 1'b1, 1'b0, mk(5'(10 + i), 32'(32'h111 * (i + 1))));
         tick();
         chk("stream_data", {b1.mem_wd, b1.mem_wdata}, {5'(10 + i), 32'(32'h111 * (i + 1))});
         chk("stream_cnt_rdy", {count1, b1.in_ready, b1.out_valid}, {2'd1, 1'b1, 1'b1});
      end
      set_in(1'b0, 1'b1, 1'b0, '0);
      tick();

      // Bubble after wd=7/wdata=0x10 in both modes.
      set_in(1'b1, 1'b1, 1'b0, mk(5'd7, 32'h10));
      tick();
      set_in(1'b0, 1'b1, 1'b0, '0);
      tick();
      chk("bubble_bz1", {b1.out_valid, b1.mem_wd, b1.mem_wdata, b1.mem_wreg}, {1'b0, 5'd0, 32'h0, 1'b0});
      chk("bubble_bz0", {b0.out_valid, b0.mem_wd, b0.mem_wdata, b0.mem_wreg}, {1'b0, 5'd7, 32'h10, 1'b0});

      // Table: skid fill and drain, simultaneous fire, flush in TWO and EMPTY.
      for (int i = 0; i < 13; i++) begin
         set_in(tbl[i].iv, tbl[i].ordy, tbl[i].fl, mk(tbl[i].wd, tbl[i].wdata));
         tick();
         chk($sformatf("tbl_row%0d", i),
             {count1, b1.in_ready, b1.out_valid, b1.mem_wreg, b1.mem_wd, b1.mem_wdata},
             {tbl[i].e_cnt, tbl[i].e_ir, tbl[i].e_ov, tbl[i].e_ov, tbl[i].e_wd, tbl[i].e_wdata});
      end

      // Random traffic with occasional flush and reset.
      for (int c = 0; c < 3000; c++) begin
         r   = {$urandom(), $urandom(), $urandom()};
         rst = ($urandom_range(0, 199) == 0);
         set_in(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                ($urandom_range(0, 31) == 0), r[80:0]);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
